// File: rtl/nabp_filtered_ram_bank_scheduler.sv
// -----------------------------------------------------------------------------
// nabp_filtered_ram_bank_scheduler
//   Sequences projection angles through the two filtered-RAM banks (ping-pong).
//   Issues one load request per angle to the filtered-RAM loader, tracks the
//   status of each bank and hands filled banks to the processing swap control
//   through the fr_next_angle / fr_next_angle_ack handshake. Moves no data.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start               pulse: begin a reconstruction (ignored while busy)
//   busy                high from the cycle after start until done
//   done                1-cycle pulse: reconstruction finished
//   ld_req              load request, held until ld_done
//   ld_bank, ld_angle   target bank / angle of the load, stable while ld_req
//   ld_done             1-cycle pulse: bank ld_bank is now filled
//   fr_next_angle       processing asks for the next angle (pulse or level)
//   fr_next_angle_ack   1-cycle grant pulse, fr0_*/fr1_* updated with it
//   fr_done             processing has drained the last angle
//   fr0_angle/_valid    angle in the bank being processed (valid=0: end marker)
//   fr1_angle/_valid    angle in the other bank (valid: that bank is FULL)
// -----------------------------------------------------------------------------
module nabp_filtered_ram_bank_scheduler #(
  parameter int ANGLE_W     = 9,
  parameter int ANGLE_COUNT = 180,
  parameter int ANGLE_STEP  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               ld_req,
  output logic               ld_bank,
  output logic [ANGLE_W-1:0] ld_angle,
  input  logic               ld_done,
  input  logic               fr_next_angle,
  output logic               fr_next_angle_ack,
  input  logic               fr_done,
  output logic [ANGLE_W-1:0] fr0_angle,
  output logic               fr0_angle_valid,
  output logic [ANGLE_W-1:0] fr1_angle,
  output logic               fr1_angle_valid
);

  localparam int                 CNT_W   = $clog2(ANGLE_COUNT + 1);
  localparam logic [CNT_W-1:0]   COUNT_C = CNT_W'(ANGLE_COUNT);
  localparam logic [ANGLE_W-1:0] STEP_C  = ANGLE_W'(ANGLE_STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  typedef enum logic [1:0] {B_EMPTY, B_LOADING, B_FULL, B_IN_USE} bank_t;

  state_t             state;
  bank_t              bank_st   [2];
  bank_t              bank_st_n [2];
  logic [ANGLE_W-1:0] bank_angle [2];
  logic               rd_sel;
  logic               rd_sel_n;
  logic               alt_sel;
  logic [CNT_W-1:0]   loads_issued;
  logic [CNT_W-1:0]   granted;
  logic [ANGLE_W-1:0] next_angle;
  logic               pend;
  logic               eoa_seen;

  logic run;
  logic ld_accept;
  logic fin_ok;
  logic req;
  logic grant_a;
  logic grant_b;
  logic grant;
  logic issue;
  logic issue_bank;

  // Decisions for this cycle, all taken from registered state. Load issue,
  // load completion and grant touch banks in disjoint states (EMPTY, LOADING,
  // FULL/IN_USE), so they may all apply in the same cycle.
  always_comb begin
    run       = (state == S_RUN);
    alt_sel   = ~rd_sel;
    ld_accept = run && ld_done && ld_req;
    fin_ok    = run && fr_done && eoa_seen;
    // A request arriving this cycle is served together with any pending one.
    req       = run && (pend || fr_next_angle);
    grant_a   = req && !fin_ok && (bank_st[alt_sel] == B_FULL);
    grant_b   = req && !fin_ok && !grant_a && (granted == COUNT_C);
    grant     = grant_a || grant_b;

    issue      = 1'b0;
    issue_bank = alt_sel;
    if (run && !fin_ok && !ld_req && (loads_issued < COUNT_C)) begin
      if (bank_st[alt_sel] == B_EMPTY) begin
        issue      = 1'b1;
        issue_bank = alt_sel;
      end else if (bank_st[rd_sel] == B_EMPTY) begin
        issue      = 1'b1;
        issue_bank = rd_sel;
      end
    end

    bank_st_n = bank_st;
    rd_sel_n  = rd_sel;
    if (ld_accept)
      bank_st_n[ld_bank] = B_FULL;
    // Only a bank actually in use is released; the first grant has none.
    if (grant && (bank_st[rd_sel] == B_IN_USE))
      bank_st_n[rd_sel] = B_EMPTY;
    if (grant_a) begin
      bank_st_n[alt_sel] = B_IN_USE;
      rd_sel_n           = alt_sel;
    end
    if (issue)
      bank_st_n[issue_bank] = B_LOADING;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      ld_req            <= 1'b0;
      ld_bank           <= 1'b0;
      ld_angle          <= '0;
      fr_next_angle_ack <= 1'b0;
      fr0_angle         <= '0;
      fr0_angle_valid   <= 1'b0;
      fr1_angle         <= '0;
      fr1_angle_valid   <= 1'b0;
      bank_st[0]        <= B_EMPTY;
      bank_st[1]        <= B_EMPTY;
      bank_angle[0]     <= '0;
      bank_angle[1]     <= '0;
      rd_sel            <= 1'b0;
      loads_issued      <= '0;
      granted           <= '0;
      next_angle        <= '0;
      pend              <= 1'b0;
      eoa_seen          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done              <= 1'b0;
          fr_next_angle_ack <= 1'b0;
          if (start) begin
            state           <= S_RUN;
            busy            <= 1'b1;
            // rd_sel starts at 1 so that the "other bank first" rule sends
            // the first load to bank 0.
            rd_sel          <= 1'b1;
            loads_issued    <= '0;
            granted         <= '0;
            next_angle      <= '0;
            pend            <= 1'b0;
            eoa_seen        <= 1'b0;
            ld_req          <= 1'b0;
            bank_st[0]      <= B_EMPTY;
            bank_st[1]      <= B_EMPTY;
            fr0_angle_valid <= 1'b0;
            fr1_angle_valid <= 1'b0;
          end
        end

        S_RUN: begin
          fr_next_angle_ack <= grant;
          pend              <= grant ? 1'b0 : (pend || fr_next_angle);
          bank_st[0]        <= bank_st_n[0];
          bank_st[1]        <= bank_st_n[1];
          rd_sel            <= rd_sel_n;

          if (issue) begin
            ld_req                 <= 1'b1;
            ld_bank                <= issue_bank;
            ld_angle               <= next_angle;
            bank_angle[issue_bank] <= next_angle;
            next_angle             <= next_angle + STEP_C;
            loads_issued           <= loads_issued + 1'b1;
          end else if (ld_accept) begin
            ld_req <= 1'b0;
          end

          if (grant_a) begin
            fr0_angle       <= bank_angle[alt_sel];
            fr0_angle_valid <= 1'b1;
            granted         <= granted + 1'b1;
          end
          if (grant_b) begin
            fr0_angle_valid <= 1'b0;
            eoa_seen        <= 1'b1;
          end
          if (grant || ld_accept) begin
            fr1_angle       <= bank_angle[~rd_sel_n];
            fr1_angle_valid <= (bank_st_n[~rd_sel_n] == B_FULL);
          end

          if (fin_ok) begin
            state           <= S_FIN;
            done            <= 1'b1;
            ld_req          <= 1'b0;
            pend            <= 1'b0;
            bank_st[0]      <= B_EMPTY;
            bank_st[1]      <= B_EMPTY;
            fr0_angle_valid <= 1'b0;
            fr1_angle_valid <= 1'b0;
          end
        end

        S_FIN: begin
          state             <= S_IDLE;
          busy              <= 1'b0;
          done              <= 1'b0;
          fr_next_angle_ack <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
